// File: rtl/sized_memory_if.sv
// Request/response port of the sized data/instruction RAM.
// The CPU side is the master and the memory is the slave.
interface sized_memory_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_fault;

  modport master (
    output req_valid, req_write, req_size,
    output req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_fault
  );

  modport slave (
    input  req_valid, req_write, req_size,
    input  req_signed, req_addr, req_wdata,
    output req_ready, resp_valid,
    output resp_rdata, resp_fault
  );
endinterface

// File: rtl/sized_memory.sv
// Byte-addressed little-endian RAM with wait states,
// sized loads/stores, sign extension and fault detection.
module sized_memory #(
  parameter int          NUM_OF_BYTES = 1024,
  parameter int          ADDR_W       = 32,
  parameter int          WAIT_STATES  = 2,
  parameter logic [31:0] FILL_WORD    = 32'hE1A00000
) (
  input logic         clk,
  input logic         reset,
  sized_memory_if.slave bus
);
  localparam int WORDS = NUM_OF_BYTES / 4;
  localparam int WW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [3:0] CNT_INIT =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [ADDR_W:0] LIMIT =
    (ADDR_W+1)'(NUM_OF_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state, state_n;
  logic [3:0] cnt;
  logic accept, commit;

  logic              wr_q, sgn_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic              wr, sgn, idle;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;

  logic [NUM_OF_BYTES*8-1:0] mem;
  logic [ADDR_W:0] nbytes, span_end;
  logic            misal, fault;
  logic [3:0]      be;
  logic [WW-1:0]   widx;
  logic [WW+4:0]   bit_base;
  logic [31:0]     word, lane, ld_data, wlanes;
  logic [31:0]     rdata_q;
  logic            fault_q;

  // With zero wait states the commit edge is the accept edge,
  // so the live request must be decoded instead of the capture.
  assign idle  = (state == IDLE);
  assign wr    = idle ? bus.req_write  : wr_q;
  assign sgn   = idle ? bus.req_signed : sgn_q;
  assign size  = idle ? bus.req_size   : size_q;
  assign addr  = idle ? bus.req_addr   : addr_q;
  assign wdata = idle ? bus.req_wdata  : wdata_q;

  always_comb begin
    nbytes = '0;
    misal  = 1'b0;
    be     = 4'b0000;
    wlanes = wdata;
    unique case (size)
      2'b00: begin
        nbytes = (ADDR_W+1)'(1);
        be     = 4'b0001 << addr[1:0];
        wlanes = {4{wdata[7:0]}};
      end
      2'b01: begin
        nbytes = (ADDR_W+1)'(2);
        misal  = addr[0];
        be     = 4'b0011 << addr[1:0];
        wlanes = {2{wdata[15:0]}};
      end
      2'b10: begin
        nbytes = (ADDR_W+1)'(4);
        misal  = |addr[1:0];
        be     = 4'b1111;
      end
      default: ;
    endcase
    span_end = {1'b0, addr} + nbytes;
    fault = (size == 2'b11) | misal | (span_end > LIMIT);
  end

  assign widx     = addr[WW+1:2];
  assign bit_base = {widx, 5'b00000};
  assign word     = mem[bit_base +: 32];
  assign lane     = word >> {addr[1:0], 3'b000};

  always_comb begin
    unique case (size)
      2'b00:   ld_data = {{24{sgn & lane[7]}}, lane[7:0]};
      2'b01:   ld_data = {{16{sgn & lane[15]}}, lane[15:0]};
      default: ld_data = lane;
    endcase
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    commit  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            state_n = RESP;
            commit  = 1'b1;
          end else begin
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_n = RESP;
          commit  = 1'b1;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
      wr_q    <= 1'b0;
      sgn_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      mem     <= {WORDS{FILL_WORD}};
    end else begin
      state <= state_n;
      if (accept) begin
        wr_q    <= bus.req_write;
        sgn_q   <= bus.req_signed;
        size_q  <= bus.req_size;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        cnt     <= CNT_INIT;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        fault_q <= fault;
        rdata_q <= (fault | wr) ? '0 : ld_data;
        if (wr && !fault) begin
          for (int b = 0; b < 4; b++) begin
            if (be[b])
              mem[bit_base + 8*b +: 8] <= wlanes[8*b +: 8];
          end
        end
      end
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_fault = fault_q;
endmodule

// File: tb/tb_sized_memory.sv
// Bench for sized_memory: directed vectors, random traffic
// against a byte-array model, handshake and reset corners.
module tb_sized_memory;
  localparam int          NB   = 1024;
  localparam int          WS   = 2;
  localparam logic [31:0] FILL = 32'hE1A00000;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   cyc;

  sized_memory_if #(.ADDR_W(32)) bus ();
  sized_memory_if #(.ADDR_W(32)) bus0 ();

  sized_memory #(
    .NUM_OF_BYTES(NB), .ADDR_W(32),
    .WAIT_STATES(WS), .FILL_WORD(FILL)
  ) dut (.clk(clk), .reset(reset), .bus(bus));

  sized_memory #(
    .NUM_OF_BYTES(NB), .ADDR_W(32),
    .WAIT_STATES(0), .FILL_WORD(FILL)
  ) dut0 (.clk(clk), .reset(reset), .bus(bus0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int acc_q[$], resp_q[$], acc0_q[$], resp0_q[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.req_valid && bus.req_ready) acc_q.push_back(cyc);
    if (bus.resp_valid) resp_q.push_back(cyc);
    if (bus0.req_valid && bus0.req_ready) acc0_q.push_back(cyc);
    if (bus0.resp_valid) resp0_q.push_back(cyc);
  end

  logic [7:0] ref_mem [NB];

  function automatic void model_fill();
    for (int i = 0; i < NB; i++)
      ref_mem[i] = 8'(FILL >> (8 * (i % 4)));
  endfunction

  function automatic void model(
    input bit wr, input logic [1:0] sz, input bit sg,
    input logic [31:0] a, input logic [31:0] wd,
    output logic [31:0] rd, output bit f);
    int n;
    longint unsigned last;
    logic [31:0] v;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    last = longint'(a) + longint'(n);
    f = (sz == 2'd3) || ((a % n) != 0) || (last > NB);
    rd = '0;
    if (f) return;
    if (wr) begin
      for (int i = 0; i < n; i++)
        ref_mem[a + i] = wd[8*i +: 8];
      return;
    end
    v = '0;
    for (int i = 0; i < n; i++)
      v = v | (32'(ref_mem[a + i]) << (8 * i));
    if (n < 4 && sg && v[8*n-1])
      v = v | (32'hFFFFFFFF << (8 * n));
    rd = v;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic idle_bus();
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
  endtask

  task automatic drive(input bit wr, input logic [1:0] sz,
                       input bit sg, input logic [31:0] a,
                       input logic [31:0] wd);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
  endtask

  task automatic do_req(input bit wr, input logic [1:0] sz,
                        input bit sg, input logic [31:0] a,
                        input logic [31:0] wd,
                        output logic [31:0] rd,
                        output logic f, output int lat);
    int g;
    @(negedge clk);
    drive(wr, sz, sg, a, wd);
    g = 0;
    while (!bus.req_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!bus.req_ready) begin
      chk("accept_timeout", 32'(bus.req_ready), 32'd1);
      idle_bus();
      rd = 'x; f = 1'bx; lat = -1;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    idle_bus();
    lat = 0;
    while (!bus.resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rd = bus.resp_rdata;
    f  = bus.resp_fault;
    @(negedge clk);
    chk("resp_pulse", 32'(bus.resp_valid), 32'd0);
  endtask

  typedef struct {
    bit          wr;
    logic [1:0]  sz;
    bit          sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    bit          f;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [31:0] rd, mrd;
    logic f;
    bit mf;
    int lat, g;
    bit wr, sg;
    logic [1:0] sz;
    logic [31:0] a, wd;

    checks = 0;
    errors = 0;
    cyc = 0;
    reset = 1'b1;
    idle_bus();
    bus0.req_valid  = 1'b0;
    bus0.req_write  = 1'b0;
    bus0.req_size   = 2'd2;
    bus0.req_signed = 1'b0;
    bus0.req_addr   = 32'h3FC;
    bus0.req_wdata  = '0;
    model_fill();

    // request held during reset must be ignored
    @(negedge clk);
    drive(1'b1, 2'd2, 1'b0, 32'h0, 32'h12345678);
    @(negedge clk);
    reset = 1'b0;
    idle_bus();
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'd0);
    chk("rst_fault", 32'(bus.resp_fault), 32'd0);
    chk("rst0_ready", 32'(bus0.req_ready), 32'd1);

    tbl.push_back('{0, 2'd2, 0, 32'h000, 0, FILL, 0});
    tbl.push_back('{0, 2'd2, 0, 32'h3FC, 0, FILL, 0});
    tbl.push_back('{1, 2'd2, 0, 32'h010, 32'h11223344, 0, 0});
    tbl.push_back('{1, 2'd0, 0, 32'h011, 32'h000000AA, 0, 0});
    tbl.push_back('{0, 2'd2, 0, 32'h010, 0, 32'h1122AA44, 0});
    tbl.push_back('{0, 2'd0, 1, 32'h011, 0, 32'hFFFFFFAA, 0});
    tbl.push_back('{0, 2'd1, 0, 32'h012, 0, 32'h00001122, 0});
    tbl.push_back('{0, 2'd1, 1, 32'h010, 0, 32'hFFFFAA44, 0});
    tbl.push_back('{0, 2'd0, 0, 32'h013, 0, 32'h00000011, 0});
    tbl.push_back('{0, 2'd2, 0, 32'h002, 0, 0, 1});
    tbl.push_back('{1, 2'd1, 0, 32'h005, 32'h5555, 0, 1});
    tbl.push_back('{0, 2'd2, 0, 32'h004, 0, FILL, 0});
    tbl.push_back('{0, 2'd3, 0, 32'h008, 0, 0, 1});
    tbl.push_back('{0, 2'd2, 0, NB - 2, 0, 0, 1});
    tbl.push_back('{0, 2'd2, 0, NB - 4, 0, FILL, 0});
    tbl.push_back('{0, 2'd1, 0, 32'hFFFFFFFE, 0, 0, 1});
    tbl.push_back('{1, 2'd2, 0, 32'h3FC, 32'h80706050, 0, 0});
    tbl.push_back('{0, 2'd0, 1, 32'h3FF, 0, 32'hFFFFFF80, 0});
    tbl.push_back('{0, 2'd0, 0, NB, 0, 0, 1});

    foreach (tbl[i]) begin
      do_req(tbl[i].wr, tbl[i].sz, tbl[i].sg, tbl[i].a,
             tbl[i].wd, rd, f, lat);
      model(tbl[i].wr, tbl[i].sz, tbl[i].sg, tbl[i].a,
            tbl[i].wd, mrd, mf);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].rd);
      chk($sformatf("vec%0d_fault", i), 32'(f), 32'(tbl[i].f));
      chk($sformatf("vec%0d_lat", i), lat, WS);
    end

    for (int i = 0; i < 150; i++) begin
      wr = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, NB - 1));
      if ($urandom_range(0, 3) != 0 && sz != 2'd3)
        a = a & ~((32'd1 << sz) - 32'd1);
      if ($urandom_range(0, 9) == 0)
        a = NB - $urandom_range(0, 8);
      if ($urandom_range(0, 19) == 0)
        a = $urandom;
      wd = $urandom;
      do_req(wr, sz, sg, a, wd, rd, f, lat);
      model(wr, sz, sg, a, wd, mrd, mf);
      chk($sformatf("rnd%0d_rdata", i), rd, mrd);
      chk($sformatf("rnd%0d_fault", i), 32'(f), 32'(mf));
      if (i % 10 == 0) chk($sformatf("rnd%0d_lat", i), lat, WS);
    end

    // back-to-back requests with valid held high
    @(negedge clk);
    acc_q.delete();
    resp_q.delete();
    drive(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    g = 0;
    while (acc_q.size() < 3 && g < 60) begin
      @(negedge clk);
      g++;
    end
    idle_bus();
    repeat (8) @(negedge clk);
    model(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, mrd, mf);
    chk("held_accepts", acc_q.size(), 3);
    chk("held_resps", resp_q.size(), 3);
    chk("held_rdata", bus.resp_rdata, mrd);
    if (acc_q.size() == 3 && resp_q.size() == 3) begin
      for (int i = 0; i < 2; i++)
        chk($sformatf("held_space%0d", i),
            acc_q[i+1] - acc_q[i], WS + 2);
      for (int i = 0; i < 3; i++)
        chk($sformatf("held_lat%0d", i),
            resp_q[i] - acc_q[i], WS + 1);
    end

    // same with zero wait states
    @(negedge clk);
    acc0_q.delete();
    resp0_q.delete();
    bus0.req_valid = 1'b1;
    g = 0;
    while (acc0_q.size() < 3 && g < 60) begin
      @(negedge clk);
      g++;
    end
    bus0.req_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("ws0_accepts", acc0_q.size(), 3);
    chk("ws0_resps", resp0_q.size(), 3);
    chk("ws0_rdata", bus0.resp_rdata, FILL);
    chk("ws0_fault", 32'(bus0.resp_fault), 32'd0);
    if (acc0_q.size() == 3 && resp0_q.size() == 3) begin
      for (int i = 0; i < 2; i++)
        chk($sformatf("ws0_space%0d", i),
            acc0_q[i+1] - acc0_q[i], 2);
      for (int i = 0; i < 3; i++)
        chk($sformatf("ws0_lat%0d", i),
            resp0_q[i] - acc0_q[i], 1);
    end

    // reset while the store waits
    @(negedge clk);
    resp_q.delete();
    drive(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF);
    @(posedge clk);
    @(negedge clk);
    idle_bus();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_fill();
    repeat (6) @(negedge clk);
    chk("rstw_no_resp", resp_q.size(), 0);
    chk("rstw_rdata", bus.resp_rdata, 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, f, lat);
    chk("rstw_load", rd, FILL);
    chk("rstw_fault", 32'(f), 32'd0);

    // reset on the commit edge of the store
    @(negedge clk);
    resp_q.delete();
    drive(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF);
    @(posedge clk);
    @(negedge clk);
    idle_bus();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_fill();
    repeat (6) @(negedge clk);
    chk("rstc_no_resp", resp_q.size(), 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, f, lat);
    chk("rstc_load", rd, FILL);
    chk("rstc_fault", 32'(f), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
